// File: rtl/mem74189_access_ctrl.sv
// Access controller / arbiter for one 16x4 74189-style SRAM with write and read requesters.
// Optional autonomous scan reader enabled by defining MEM_SCAN_EN.
module mem74189_access_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int STROBE_CYC = 1,
  parameter int SCAN_DIV   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout_n,
  output logic              busy
`ifdef MEM_SCAN_EN
  ,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data
`endif
);

  localparam int unsigned STROBE_N = (STROBE_CYC < 1) ? 32'd1 : 32'(STROBE_CYC);
  localparam int unsigned SCAN_N   = (SCAN_DIV < 1) ? 32'd1 : 32'(SCAN_DIV);
  // One timer serves both the strobe length and the idle-to-scan delay.
  localparam int unsigned TMR_MAX  = (STROBE_N > SCAN_N) ? STROBE_N : SCAN_N;
  localparam int unsigned TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RECOVER} state_t;
  typedef enum logic [1:0] {OP_WR, OP_RD, OP_SCAN} op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              prio_wr_q, prio_wr_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              wr_done_q, wr_done_d;
  logic              rd_done_q, rd_done_d;
  logic              busy_q, busy_d;
  logic              start_wr_c, start_rd_c, start_scan_c;
  logic              strobe_last_c;
  logic              scan_fire_c;

`ifdef MEM_SCAN_EN
  logic [ADDR_W-1:0] scan_ptr_q, scan_ptr_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic [DATA_W-1:0] scan_data_q, scan_data_d;
  assign scan_fire_c = (tmr_q == TMR_W'(SCAN_N - 1));
`else
  assign scan_fire_c = 1'b0;
`endif

  assign strobe_last_c = (tmr_q == TMR_W'(STROBE_N - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_WR;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic with round-robin arbitration; scan only when nobody asks
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    start_wr_c   = 1'b0;
    start_rd_c   = 1'b0;
    start_scan_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_req && (!rd_req || prio_wr_q)) begin
          start_wr_c = 1'b1;
          op_d       = OP_WR;
          state_d    = S_SETUP;
        end else if (rd_req) begin
          start_rd_c = 1'b1;
          op_d       = OP_RD;
          state_d    = S_SETUP;
        end else if (scan_fire_c) begin
          start_scan_c = 1'b1;
          op_d         = OP_SCAN;
          state_d      = S_SETUP;
        end
      end
      S_SETUP:   state_d = S_STROBE;
      S_STROBE:  if (strobe_last_c) state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; every visible output is a flop
  always_comb begin
    mem_cs_d   = (state_d == S_IDLE);
    mem_we_d   = !((state_d == S_STROBE) && (op_d == OP_WR));
    busy_d     = (state_d != S_IDLE);
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rd_data_d  = rd_data_q;
    prio_wr_d  = prio_wr_q;
    wr_gnt_d   = start_wr_c;
    rd_gnt_d   = start_rd_c;
    wr_done_d  = (state_q == S_RECOVER) && (op_q == OP_WR);
    rd_done_d  = (state_q == S_RECOVER) && (op_q == OP_RD);
    tmr_d      = '0;
`ifdef MEM_SCAN_EN
    scan_ptr_d  = scan_ptr_q;
    scan_addr_d = scan_addr_q;
    scan_data_d = scan_data_q;
`endif

    if (start_wr_c) begin
      mem_addr_d = wr_addr;
      mem_din_d  = wr_data;
      prio_wr_d  = 1'b0;
    end
    if (start_rd_c) begin
      mem_addr_d = rd_addr;
      prio_wr_d  = 1'b1;
    end

`ifdef MEM_SCAN_EN
    if (start_scan_c) mem_addr_d = scan_ptr_q;
    if ((state_q == S_IDLE) && (state_d == S_IDLE)) tmr_d = tmr_q + TMR_W'(1);
`endif

    if ((state_q == S_STROBE) && !strobe_last_c) tmr_d = tmr_q + TMR_W'(1);

    // Capture on the last strobe cycle; the SRAM drives complemented data
    if ((state_q == S_STROBE) && strobe_last_c) begin
      if (op_q == OP_RD) rd_data_d = ~mem_dout_n;
`ifdef MEM_SCAN_EN
      if (op_q == OP_SCAN) begin
        scan_data_d = ~mem_dout_n;
        scan_addr_d = mem_addr_q;
        scan_ptr_d  = scan_ptr_q + ADDR_W'(1);
      end
`endif
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_q      <= '0;
      prio_wr_q  <= 1'b1;
      mem_cs_q   <= 1'b1;
      mem_we_q   <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rd_data_q  <= '0;
      wr_gnt_q   <= 1'b0;
      rd_gnt_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      prio_wr_q  <= prio_wr_d;
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rd_data_q  <= rd_data_d;
      wr_gnt_q   <= wr_gnt_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
      busy_q     <= busy_d;
    end
  end

`ifdef MEM_SCAN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_ptr_q  <= '0;
      scan_addr_q <= '0;
      scan_data_q <= '0;
    end else begin
      scan_ptr_q  <= scan_ptr_d;
      scan_addr_q <= scan_addr_d;
      scan_data_q <= scan_data_d;
    end
  end

  assign scan_addr = scan_addr_q;
  assign scan_data = scan_data_q;
`endif

  assign wr_gnt   = wr_gnt_q;
  assign wr_done  = wr_done_q;
  assign rd_gnt   = rd_gnt_q;
  assign rd_done  = rd_done_q;
  assign rd_data  = rd_data_q;
  assign mem_cs   = mem_cs_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem74189_access_ctrl.sv
// Self-checking bench for mem74189_access_ctrl with a behavioural 74189 (inverted outputs).
// Scan checks are compiled in when MEM_SCAN_EN is defined.
module tb_mem74189_access_ctrl;
  localparam int S = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req, rd_req;
  logic [3:0] wr_addr, wr_data, rd_addr;
  logic       wr_gnt, wr_done, rd_gnt, rd_done;
  logic [3:0] rd_data;
  logic       mem_cs, mem_we;
  logic [3:0] mem_addr, mem_din, mem_dout_n;
  logic       busy;
`ifdef MEM_SCAN_EN
  logic [3:0] scan_addr, scan_data;
`endif

  always #5 clk = ~clk;

  mem74189_access_ctrl #(.ADDR_W(4), .DATA_W(4), .STROBE_CYC(S), .SCAN_DIV(8)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_done(rd_done), .rd_data(rd_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout_n(mem_dout_n), .busy(busy)
`ifdef MEM_SCAN_EN
    , .scan_addr(scan_addr), .scan_data(scan_data)
`endif
  );

  // Behavioural 74189: writes while CS and WE are low, complemented read data
  logic [3:0] sram [16];
  initial for (int i = 0; i < 16; i++) sram[i] = 4'h0;
  always @(posedge clk) if (!mem_cs && !mem_we) sram[mem_addr] <= mem_din;
  assign mem_dout_n = (!mem_cs && mem_we) ? ~sram[mem_addr] : 4'hF;

  typedef struct {
    bit         is_wr;
    logic [3:0] data;
  } exp_t;

  typedef struct {
    bit         is_wr;
    logic [3:0] addr;
    logic [3:0] data;
    logic [3:0] exp;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         tests = 0, fails = 0;
  int         cyc = 0, gnt_cyc = 0, last_done_cyc = 0, we_low = 0;
  int         scan_cd = 0, scan_start_cyc = 0, scans_seen = 0;
  logic       busy_prev = 1'b0;
  logic [3:0] last_rd = 4'h0;
  logic [3:0] scan_exp = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: timing, scoreboard pops and scan tracking, sampled after the edge
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      busy_prev = 1'b0;
      scan_cd   = 0;
    end else begin
      cyc++;
      if (scan_cd > 0) begin
        scan_cd--;
        if (scan_cd == 0) begin
`ifdef MEM_SCAN_EN
          check("scan_addr", 32'(scan_addr), 32'(scan_exp));
          check("scan_data", 32'(scan_data), 32'(scan_exp));
`endif
          scan_exp = scan_exp + 4'h1;
          scans_seen++;
        end
      end
      if (busy && !busy_prev) begin
`ifdef MEM_SCAN_EN
        if (!wr_gnt && !rd_gnt) begin
          scan_cd        = 1 + S;
          scan_start_cyc = cyc;
        end
`else
        check("start_has_gnt", 32'(wr_gnt | rd_gnt), 32'd1);
`endif
      end
      if (wr_gnt || rd_gnt) begin
        gnt_cyc = cyc;
        we_low  = 0;
      end
      if (!mem_we) we_low++;
      if (wr_done || rd_done) begin
        check("done_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("done_kind", 32'(wr_done), 32'(mon_e.is_wr));
          check("done_latency", 32'(cyc - gnt_cyc), 32'(2 + S));
          if (mon_e.is_wr) begin
            check("wr_we_low_cycles", 32'(we_low), 32'(S));
            check("rd_data_held", 32'(rd_data), 32'(last_rd));
          end else begin
            check("rd_data", 32'(rd_data), 32'(mon_e.data));
            check("rd_we_low_cycles", 32'(we_low), 32'd0);
            last_rd = mon_e.data;
          end
        end
        last_done_cyc = cyc;
      end
      busy_prev = busy;
    end
  end

  task automatic rst_pulse();
    @(posedge clk);
    #3 reset = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    #1;
    check("rst_mem_cs", 32'(mem_cs), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd1);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    exp_q.delete();
    last_rd  = 4'h0;
    scan_exp = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic issue(input bit is_wr, input logic [3:0] a, input logic [3:0] d,
                       input logic [3:0] e);
    exp_t x;
    bit   ok;
    x.is_wr = is_wr;
    x.data  = is_wr ? d : e;
    exp_q.push_back(x);
    @(negedge clk);
    if (is_wr) begin
      wr_addr = a; wr_data = d; wr_req = 1'b1;
    end else begin
      rd_addr = a; rd_req = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      #2 ok = is_wr ? wr_gnt : rd_gnt;
    end
    check(is_wr ? "wr_gnt_seen" : "rd_gnt_seen", 32'(ok), 32'd1);
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = ~a; wr_data = ~d; rd_addr = ~a;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      #2 ok = wr_done | rd_done;
    end
    check("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic arb(input bit exp_wr);
    exp_t x;
    bit   ok;
    x.is_wr = exp_wr;
    x.data  = exp_wr ? 4'h6 : 4'hA;
    exp_q.push_back(x);
    @(negedge clk);
    wr_addr = 4'h8; wr_data = 4'h6; rd_addr = 4'h3;
    wr_req = 1'b1; rd_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      #2 ok = wr_gnt | rd_gnt;
    end
    check("arb_gnt_seen", 32'(ok), 32'd1);
    check("arb_wr_gnt", 32'(wr_gnt), 32'(exp_wr));
    check("arb_rd_gnt", 32'(rd_gnt), 32'(!exp_wr));
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    wait_done();
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 4'h3, 4'hA, 4'h0};
    vecs[1]  = '{1'b0, 4'h3, 4'h0, 4'hA};
    vecs[2]  = '{1'b1, 4'hF, 4'h5, 4'h0};
    vecs[3]  = '{1'b1, 4'h0, 4'hC, 4'h0};
    vecs[4]  = '{1'b0, 4'hF, 4'h0, 4'h5};
    vecs[5]  = '{1'b0, 4'h0, 4'h0, 4'hC};
    vecs[6]  = '{1'b1, 4'h7, 4'h3, 4'h0};
    vecs[7]  = '{1'b0, 4'h7, 4'h0, 4'h3};
    vecs[8]  = '{1'b1, 4'h9, 4'hF, 4'h0};
    vecs[9]  = '{1'b0, 4'h9, 4'h0, 4'hF};
    vecs[10] = '{1'b1, 4'h1, 4'h0, 4'h0};
    vecs[11] = '{1'b0, 4'h3, 4'h0, 4'hA};

    reset = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = 4'h0; wr_data = 4'h0; rd_addr = 4'h0;
    rst_pulse();

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
      wait_done();
    end

    // Re-request right away: granted one cycle after the previous done
    issue(1'b0, 4'h9, 4'h0, 4'hF);
    issue(1'b0, 4'h9, 4'h0, 4'hF);
    check("b2b_gap", 32'(gnt_cyc - last_done_cyc), 32'd1);
    wait_done();

    rst_pulse();
    arb(1'b1);
    arb(1'b0);
    arb(1'b1);
    arb(1'b0);

    // Reset during a write strobe: WE released at once, no done
    issue(1'b1, 4'h5, 4'h6, 4'h0);
    @(posedge clk);
    #2 check("we_low_in_strobe", 32'(mem_we), 32'd0);
    #1 reset = 1'b0;
    #1;
    check("midop_mem_we", 32'(mem_we), 32'd1);
    check("midop_mem_cs", 32'(mem_cs), 32'd1);
    check("midop_busy", 32'(busy), 32'd0);
    exp_q.delete();
    last_rd = 4'h0;
    scan_exp = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("midop_idle_after", 32'(busy), 32'd0);

`ifdef MEM_SCAN_EN
    for (int k = 0; k < 16; k++) begin
      issue(1'b1, 4'(k), 4'(k), 4'h0);
      wait_done();
    end
    rst_pulse();
    for (int i = 0; i < 600 && scans_seen < 17; i++) @(posedge clk);
    check("scan_count", 32'(scans_seen >= 17), 32'd1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(posedge clk);
        #2 seen = (scan_cd > 0);
      end
      check("scan_started", 32'(seen), 32'd1);
      issue(1'b0, 4'h4, 4'h0, 4'h4);
      check("rd_after_scan_gap", 32'(gnt_cyc - scan_start_cyc), 32'(3 + S));
      wait_done();
    end
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
